// File: rtl/parallel_rw_lock.sv
// Shared/exclusive lock arbiter: each port acquires a read or write hold,
// granted in wrap-around issue-ID order so a pending writer is never overtaken.
module parallel_rw_lock #(
  parameter int NUM_PORTS = 4,
  parameter int ID_WIDTH  = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_PORTS-1:0]                req_read,
  input  logic [NUM_PORTS-1:0]                req_write,
  input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0]  req_issue_id,
  input  logic [NUM_PORTS-1:0]                release_lock,
  output logic [NUM_PORTS-1:0]                grant,
  output logic                                lock_busy
);

  typedef enum logic [1:0] {MODE_IDLE, MODE_READ, MODE_WRITE} mode_e;

  mode_e                mode_q, mode_d;
  logic [NUM_PORTS-1:0] held_q, held_d;

  logic [NUM_PORTS-1:0] pending, pend_wr, pend_rd;
  logic [NUM_PORTS-1:0] old_vec, new_gnt;
  logic [ID_WIDTH-1:0]  old_id, wr_id;
  int                   old_idx, wr_idx;
  logic                 any_pend, any_wr, wr_gnt;

  // Wrap-around age: a is older when (a - b) read as a signed tag is negative.
  function automatic logic is_older(input logic [ID_WIDTH-1:0] a_id, input int a_idx,
                                    input logic [ID_WIDTH-1:0] b_id, input int b_idx);
    logic [ID_WIDTH-1:0]        raw;
    logic signed [ID_WIDTH-1:0] diff;
    raw  = a_id - b_id;
    diff = $signed(raw);
    return (diff < 0) || ((a_id == b_id) && (a_idx < b_idx));
  endfunction

  always_comb begin
    pending  = (req_read | req_write) & ~held_q;
    pend_wr  = pending & req_write;
    pend_rd  = pending & ~req_write;
    any_pend = 1'b0;
    any_wr   = 1'b0;
    old_vec  = '0;
    old_id   = '0;
    old_idx  = 0;
    wr_id    = '0;
    wr_idx   = 0;
    new_gnt  = '0;
    wr_gnt   = 1'b0;

    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pending[i] && (!any_pend || is_older(req_issue_id[i], i, old_id, old_idx))) begin
        any_pend   = 1'b1;
        old_vec    = '0;
        old_vec[i] = 1'b1;
        old_id     = req_issue_id[i];
        old_idx    = i;
      end
      if (pend_wr[i] && (!any_wr || is_older(req_issue_id[i], i, wr_id, wr_idx))) begin
        any_wr = 1'b1;
        wr_id  = req_issue_id[i];
        wr_idx = i;
      end
    end

    // Acquisition looks only at pre-release holds; releases land on the same edge.
    if ((held_q == '0) && any_pend && ((old_vec & pend_wr) != '0)) begin
      new_gnt = old_vec;
      wr_gnt  = 1'b1;
    end else if (mode_q != MODE_WRITE) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (pend_rd[i] && (!any_wr || is_older(req_issue_id[i], i, wr_id, wr_idx)))
          new_gnt[i] = 1'b1;
      end
    end

    held_d = (held_q & ~release_lock) | new_gnt;

    if (held_d == '0)            mode_d = MODE_IDLE;
    else if (wr_gnt)             mode_d = MODE_WRITE;
    else if (mode_q == MODE_IDLE) mode_d = MODE_READ;
    else                         mode_d = mode_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q <= '0;
      mode_q <= MODE_IDLE;
    end else begin
      held_q <= held_d;
      mode_q <= mode_d;
    end
  end

  assign grant     = held_q;
  assign lock_busy = |held_q;

endmodule

// File: tb/tb_parallel_rw_lock.sv
// Bench for parallel_rw_lock: directed ordering scenarios plus random traffic
// compared against a per-port hold-kind reference model.
module tb_parallel_rw_lock;

  localparam int NP = 4;
  localparam int IW = 4;

  logic                  clk;
  logic                  rst_n;
  logic [NP-1:0]         req_read, req_write, release_lock;
  logic [NP-1:0][IW-1:0] req_issue_id;
  logic [NP-1:0]         grant;
  logic                  lock_busy;

  int n_checks;
  int n_errors;

  // kind_m[p]: 0 = not held, 1 = read hold, 2 = write hold
  int kind_m[NP];

  parallel_rw_lock #(.NUM_PORTS(NP), .ID_WIDTH(IW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_issue_id (req_issue_id),
    .release_lock (release_lock),
    .grant        (grant),
    .lock_busy    (lock_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NP-1:0] model_held();
    logic [NP-1:0] h;
    for (int p = 0; p < NP; p++) h[p] = (kind_m[p] != 0);
    return h;
  endfunction

  // a older than b: modular distance a->b in the upper half of the tag space
  function automatic bit older_m(input int a_id, input int a_p, input int b_id, input int b_p);
    int d;
    d = (a_id - b_id + (1 << IW)) % (1 << IW);
    if (d == 0) return a_p < b_p;
    return d >= (1 << (IW - 1));
  endfunction

  task automatic cycle(input logic [NP-1:0] rd, input logic [NP-1:0] wr,
                       input logic [NP-1:0] rel, input logic [NP*IW-1:0] ids);
    int  nxt[NP];
    int  pend[$];
    int  id[NP];
    int  oldest;
    bit  any_held, write_held, ok;
    req_read     = rd;
    req_write    = wr;
    release_lock = rel;
    req_issue_id = ids;

    any_held = 0;
    write_held = 0;
    for (int p = 0; p < NP; p++) begin
      id[p]  = int'(ids[p*IW +: IW]);
      nxt[p] = rel[p] ? 0 : kind_m[p];
      if (kind_m[p] != 0) any_held = 1;
      if (kind_m[p] == 2) write_held = 1;
      if ((rd[p] || wr[p]) && kind_m[p] == 0) pend.push_back(p);
    end

    oldest = -1;
    foreach (pend[a]) begin
      ok = 1;
      foreach (pend[b])
        if (a != b && older_m(id[pend[b]], pend[b], id[pend[a]], pend[a])) ok = 0;
      if (ok) oldest = pend[a];
    end

    if (!any_held && oldest >= 0 && wr[oldest]) begin
      nxt[oldest] = 2;
    end else if (!write_held) begin
      foreach (pend[a]) begin
        if (!wr[pend[a]]) begin
          ok = 1;
          foreach (pend[b])
            if (wr[pend[b]] && !older_m(id[pend[a]], pend[a], id[pend[b]], pend[b])) ok = 0;
          if (ok) nxt[pend[a]] = 1;
        end
      end
    end

    @(posedge clk);
    for (int p = 0; p < NP; p++) kind_m[p] = nxt[p];
    @(negedge clk);
    check("grant", 32'(grant), 32'(model_held()));
    check("lock_busy", 32'(lock_busy), 32'(model_held() != '0));
    for (int p = 0; p < NP; p++)
      if (kind_m[p] == 2) check("write_exclusive", 32'($countones(grant)), 32'd1);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(lock_busy), 32'd0);
    for (int p = 0; p < NP; p++) kind_m[p] = 0;
    req_read = '0; req_write = '0; release_lock = '0;
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_grant", 32'(grant), 32'd0);
  endtask

  function automatic logic [NP*IW-1:0] mk_ids(input int i0, input int i1, input int i2, input int i3);
    logic [NP*IW-1:0] v;
    v[3:0] = 4'(i0); v[7:4] = 4'(i1); v[11:8] = 4'(i2); v[15:12] = 4'(i3);
    return v;
  endfunction

  initial begin
    logic [NP-1:0]    rd, wr, rel;
    logic [NP*IW-1:0] ids;
    int               base, r;
    n_checks = 0;
    n_errors = 0;
    for (int p = 0; p < NP; p++) kind_m[p] = 0;
    rst_n = 1'b0;
    req_read = '0; req_write = '0; release_lock = '0; req_issue_id = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_busy", 32'(lock_busy), 32'd0);
    rst_n = 1'b1;

    // single read, then release
    cycle(4'b0001, 4'b0000, 4'b0000, mk_ids(3, 0, 0, 0));
    check("single_rd_grant", 32'(grant), 32'h1);
    cycle(4'b0000, 4'b0000, 4'b0001, mk_ids(3, 0, 0, 0));
    check("single_rd_rel", 32'(grant), 32'h0);

    // parallel reads, then async reset mid-hold
    cycle(4'b0111, 4'b0000, 4'b0000, mk_ids(1, 2, 3, 0));
    check("par_rd_grant", 32'(grant), 32'h7);
    async_reset();

    // issue order: older read first, writer next, younger read last
    cycle(4'b0110, 4'b0001, 4'b0000, mk_ids(5, 4, 6, 0));
    check("ord_rd_first", 32'(grant), 32'h2);
    cycle(4'b0100, 4'b0001, 4'b0000, mk_ids(5, 4, 6, 0));
    check("ord_rd_blocked", 32'(grant), 32'h2);
    cycle(4'b0100, 4'b0001, 4'b0010, mk_ids(5, 4, 6, 0));
    check("ord_rel_gap", 32'(grant), 32'h0);
    cycle(4'b0100, 4'b0001, 4'b0000, mk_ids(5, 4, 6, 0));
    check("ord_wr_grant", 32'(grant), 32'h1);
    cycle(4'b0110, 4'b0000, 4'b0000, mk_ids(5, 1, 6, 0));
    check("ord_wr_excl", 32'(grant), 32'h1);
    cycle(4'b0100, 4'b0000, 4'b0001, mk_ids(5, 4, 6, 0));
    check("ord_wr_rel", 32'(grant), 32'h0);
    cycle(4'b0100, 4'b0000, 4'b0000, mk_ids(5, 4, 6, 0));
    check("ord_late_rd", 32'(grant), 32'h4);
    cycle(4'b0000, 4'b0000, 4'b0110, mk_ids(0, 0, 0, 0));

    // wrap-around: id 15 is older than id 0
    cycle(4'b0000, 4'b0011, 4'b0000, mk_ids(15, 0, 0, 0));
    check("wrap_first", 32'(grant), 32'h1);
    cycle(4'b0000, 4'b0010, 4'b0001, mk_ids(15, 0, 0, 0));
    check("wrap_gap", 32'(grant), 32'h0);
    cycle(4'b0000, 4'b0010, 4'b0000, mk_ids(15, 0, 0, 0));
    check("wrap_second", 32'(grant), 32'h2);
    cycle(4'b0000, 4'b0000, 4'b0010, mk_ids(0, 0, 0, 0));

    // random traffic; IDs stay within half the tag space of a moving base
    for (int c = 0; c < 600; c++) begin
      base = $urandom_range(0, 15);
      for (int p = 0; p < NP; p++) begin
        r = $urandom_range(0, 99);
        rd[p]  = (r < 35) || (r >= 55 && r < 60);
        wr[p]  = (r >= 35 && r < 60);
        rel[p] = ($urandom_range(0, 99) < 30);
        ids[p*IW +: IW] = 4'((base + $urandom_range(0, 7)) % 16);
      end
      cycle(rd, wr, rel, ids);
      if (c % 200 == 150) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/parallel_rw_lock.md
PARALLEL_RW_LOCK -- requirements
Module: parallel_rw_lock

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of requesting ports (>=1).
REQ-002 SHALL have parameter ID_WIDTH, default 4, width of the issue-ID tag (>=2).
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port req_read, input, [NUM_PORTS] x 1, per-port shared (read) lock request.
REQ-006 SHALL have port req_write, input, [NUM_PORTS] x 1, per-port exclusive (write) lock request.
REQ-007 SHALL have port req_issue_id, input, [NUM_PORTS] x ID_WIDTH, per-port issue ID of the request; smaller modular age means older.
REQ-008 SHALL have port release_lock, input, [NUM_PORTS] x 1, per-port release of a held lock.
REQ-009 SHALL have port grant, output, [NUM_PORTS] x 1, per-port "lock held" flag, registered.
REQ-010 SHALL have port lock_busy, output, 1, high when any port holds the lock.

Function
REQ-011 SHALL keep a per-port held bit and a mode (IDLE, READ, WRITE); grant[i] equals held bit i; lock_busy = OR of held bits; mode IDLE when no bit is held.
REQ-012 SHALL treat port i as pending when (req_read[i] or req_write[i]) is high and held[i] is low; both high means a write request.
REQ-013 SHALL order pending requests by issue ID with wrap-around: a is older than b when (a - b) mod 2^ID_WIDTH, read as signed ID_WIDTH, is negative; equal IDs tie-break to the lower port index.
REQ-014 SHALL, in a cycle where the oldest pending request is a write and no bit is held, set only that port's held bit at the next edge (mode WRITE).
REQ-015 SHALL, when no write is held, set at the next edge the held bits of every pending read that is older than the oldest pending write (all pending reads if no write pending); mode READ.
REQ-016 SHALL grant nothing new while mode is WRITE, and SHALL never grant a read younger than a pending write (strict issue order, no writer starvation).
REQ-017 SHALL let new reads join an active READ hold only under REQ-015.
REQ-018 SHALL clear held[i] at the next edge when release_lock[i] is high; release_lock on a non-held port is ignored.
REQ-019 SHALL evaluate acquisitions on pre-release state: a port released in cycle N cannot reacquire before cycle N+1, and a write waiting on releasing readers is granted the edge after the last release.
REQ-020 SHALL keep a held bit set until release even if the requester drops req_read/req_write; a pending request dropped before grant is withdrawn without effect.
REQ-021 SHALL have grant latency of exactly one cycle from an eligible request to grant high.
REQ-022 SHALL guarantee a write hold is exclusive: at most one held bit while mode is WRITE.

Reset
REQ-023 SHALL, while rst_n is low (asynchronously), clear all held bits, force mode IDLE, grant all 0 and lock_busy 0; reset mid-hold drops all locks.
REQ-024 SHALL resume arbitration at the first rising edge after rst_n deasserts.

Verification
REQ-025 Single read: port0 req_read, id 3, idle -> grant[0]=1 and lock_busy=1 next cycle; release_lock[0] -> both 0 one cycle later.
REQ-026 Parallel reads: ports 0,1,2 req_read ids 1,2,3 same cycle -> all three grants rise together next cycle.
REQ-027 Order: port0 write id 5, port1 read id 4 -> port1 granted first; port0 granted the cycle after port1 releases; read id 6 on port2 waits until port0 releases.
REQ-028 Wrap-around (ID_WIDTH=4): port0 write id 15, port1 write id 0 -> port0 granted first, port1 only after port0 releases.
REQ-029 Exclusivity: port0 holds write, port1 read id older -> port1 grant stays 0 until port0 releases.
REQ-030 Reset: assert rst_n=0 while two reads held -> grant all 0, lock_busy 0 immediately, without a clock edge.
